seven_seg_to_binary: RTL and testbench
======================================

# seven_seg_to_binary

Registered decoder that turns a 7-segment drive pattern back into a 4-bit BCD digit. It sits on the display side of the binary counter and serves as a loopback checker or segment-bus monitor. It samples the seven segment lines each clock and requires the pattern to stay stable for a programmable number of cycles. Only then does it accept the pattern and classify it as a digit, a blank or an illegal pattern.

## Interface
- STABLE_CYCLES, 4: consecutive unchanged clocks required before a pattern is accepted; legal range 1..255.
- i_Clk  in  1  rising-edge clock.
- i_Rst  in  1  reset, asynchronous and active-high.
- i_Seg_a .. i_Seg_g  in  1 each  segment lines, synchronous to i_Clk; pattern P = {a,b,c,d,e,f,g} = P[6:0].
- o_Binary  out  4  last accepted digit, 0..9; held between acceptances.
- o_Valid  out  1  one-cycle pulse when a digit pattern is accepted.
- o_Blank  out  1  level; high while the last accepted pattern is 7'h00.
- o_Error  out  1  one-cycle pulse when an illegal pattern is accepted.
- o_Err_Count  out  8  saturating illegal-pattern count; present only with SEG7_ERR_COUNT_EN.

## Operation
- Decode table (P -> digit):
  - 7E->0, 30->1, 6D->2, 79->3, 33->4
  - 5B->5, 5F->6, 70->7, 7F->8, 7B->9
  - 00 -> blank; any other value -> illegal.
- Internal state: r_Seg (7-bit held pattern), r_Cnt (8-bit), two-state FSM S_TRACK / S_LOCKED.
- Every edge, raw pattern P != r_Seg:
  - r_Seg <= P, r_Cnt <= 0, state -> S_TRACK.
  - This takes priority in every state.
- Every edge, P == r_Seg in S_TRACK, r_Cnt < STABLE_CYCLES-1: r_Cnt increments.
- Every edge, P == r_Seg in S_TRACK, r_Cnt == STABLE_CYCLES-1: accept, state -> S_LOCKED.
  - Digit: o_Binary <= digit, o_Valid <= 1, o_Blank <= 0.
  - Blank: o_Blank <= 1, o_Binary held, no pulse.
  - Illegal: o_Error <= 1, o_Blank <= 0, o_Binary held, error counter +1 (saturates at 255).
- S_LOCKED: no action until P changes. A held pattern is accepted exactly once.
- Re-acceptance of the same pattern requires an intervening different pattern, even a one-cycle glitch.
- A glitch during S_TRACK restarts the count from the glitch pattern. The previously accepted outputs stay unchanged.
- o_Valid and o_Error are never high in the same cycle.

## Timing
- Reset values, applied immediately and asynchronously:
  - o_Binary = 0, o_Valid = 0, o_Error = 0, o_Blank = 1, o_Err_Count = 0.
  - r_Seg = 7'h00, r_Cnt = 0, state = S_TRACK.
- Reset asserted mid-filter discards the pending pattern. Reset asserted while a pulse is high clears the pulse at once.
- Latency: new pattern first present at edge 0 -> r_Seg loaded at edge 0 -> accepted at edge STABLE_CYCLES.
  - Outputs are registered and visible in the cycle after that edge.
  - With default 4: edges 0..4, pulse high for the cycle following edge 4.
- STABLE_CYCLES = 1: accept at edge 1.
- After reset release with P held at 7'h00: silent blank acceptance at edge STABLE_CYCLES; o_Blank stays 1.
- Pulses last exactly one clock. Minimum spacing between two acceptances is STABLE_CYCLES+1 clocks.

## Configuration
- SEG7_ERR_COUNT_EN defined:
  - o_Err_Count port and its 8-bit counter are present.
  - Counter increments on each illegal acceptance and saturates at 255 (no wrap).
  - Cleared only by i_Rst.
- SEG7_ERR_COUNT_EN undefined: port and counter are absent. o_Error behaviour is unchanged.

## Test plan
- Reset, then P=7'h30 held: o_Valid pulses once, 4 edges after the first sampling edge, with o_Binary=1 and o_Blank falls to 0. P held 20 more cycles -> no further pulse.
- Sweep P through all ten digit codes, each held 6 cycles -> ten o_Valid pulses with o_Binary = 0..9 in order.
- P=7'h5B, with a one-cycle 7'h7F glitch at count 2, then 7'h5B held:
  - 7'h7F is never accepted.
  - The single pulse carries o_Binary=5, 4 edges after the glitch clears.
- Illegal P=7'h01 held, then 7'h7E, repeated 300 times:
  - 300 o_Error pulses, no o_Valid for 7'h01.
  - o_Err_Count saturates at 255 (macro on); port absent (macro off).
- P=7'h00 after digit 9 -> o_Blank=1, o_Binary stays 9, no pulse. Then 7'h79 -> o_Valid, o_Binary=3, o_Blank=0.
- i_Rst asserted at count 2 of a 7'h33 filter -> outputs go to reset values immediately. After release, with 7'h33 held, accept at edge STABLE_CYCLES counted from release.

Source files
------------

// File: rtl/seven_seg_to_binary.sv
// -----------------------------------------------------------------------------
// seven_seg_to_binary
//
// Registered 7-segment to BCD decoder used as a loopback checker / segment-bus
// monitor. The seven segment lines are sampled every clock; a pattern must stay
// unchanged for STABLE_CYCLES consecutive clocks before it is accepted and
// classified as a digit (0..9), a blank (all segments off) or an illegal code.
// A held pattern is accepted exactly once; accepting the same pattern again
// needs some different pattern in between, even a single-cycle glitch.
//
// Optional feature: define SEG7_ERR_COUNT_EN to add the o_Err_Count port, an
// 8-bit saturating count of illegal acceptances cleared only by reset.
// -----------------------------------------------------------------------------
module seven_seg_to_binary #(
    parameter int unsigned STABLE_CYCLES = 4  // legal range 1..255
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Seg_a,
    input  logic       i_Seg_b,
    input  logic       i_Seg_c,
    input  logic       i_Seg_d,
    input  logic       i_Seg_e,
    input  logic       i_Seg_f,
    input  logic       i_Seg_g,
    output logic [3:0] o_Binary,
    output logic       o_Valid,
    output logic       o_Blank,
    output logic       o_Error
`ifdef SEG7_ERR_COUNT_EN
    ,
    output logic [7:0] o_Err_Count
`endif
);

    // -------------------------------------------------------------------------
    // Types
    // -------------------------------------------------------------------------
    typedef enum logic {
        S_TRACK,   // pattern is being timed for stability
        S_LOCKED   // current pattern already accepted; wait for a change
    } state_t;

    typedef enum logic [1:0] {
        KIND_DIGIT,
        KIND_BLANK,
        KIND_ILLEGAL
    } kind_t;

    typedef struct packed {
        kind_t      kind;
        logic [3:0] digit;
    } decode_t;

    // The counter compares against this value on the edge that accepts.
    localparam logic [7:0] LAST_COUNT = 8'(STABLE_CYCLES - 1);

    // Reject out-of-range filter lengths at elaboration time.
    if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255) begin : g_bad_stable_cycles
        $error("seven_seg_to_binary: STABLE_CYCLES must be in 1..255");
    end

    // -------------------------------------------------------------------------
    // Segment pattern decode: P = {a,b,c,d,e,f,g}
    // -------------------------------------------------------------------------
    function automatic decode_t decode_pattern(input logic [6:0] pattern);
        decode_t result;
        result.kind  = KIND_DIGIT;
        result.digit = 4'd0;
        case (pattern)
            7'h7E:   result.digit = 4'd0;
            7'h30:   result.digit = 4'd1;
            7'h6D:   result.digit = 4'd2;
            7'h79:   result.digit = 4'd3;
            7'h33:   result.digit = 4'd4;
            7'h5B:   result.digit = 4'd5;
            7'h5F:   result.digit = 4'd6;
            7'h70:   result.digit = 4'd7;
            7'h7F:   result.digit = 4'd8;
            7'h7B:   result.digit = 4'd9;
            7'h00:   result.kind  = KIND_BLANK;
            default: result.kind  = KIND_ILLEGAL;
        endcase
        return result;
    endfunction

    // -------------------------------------------------------------------------
    // Internal state
    // -------------------------------------------------------------------------
    logic [6:0] seg_pattern;   // raw sampled pattern
    logic [6:0] held_seg;      // pattern currently being timed / locked
    logic [7:0] stable_cnt;    // clocks the held pattern has stayed unchanged
    state_t     state;
    state_t     state_next;
    logic       seg_changed;
    logic       accept;
    decode_t    held_decode;

    assign seg_pattern = {i_Seg_a, i_Seg_b, i_Seg_c, i_Seg_d,
                          i_Seg_e, i_Seg_f, i_Seg_g};

    // Change detection, acceptance strobe and FSM next-state logic.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        seg_changed = (seg_pattern != held_seg);
        accept      = 1'b0;
        held_decode = decode_pattern(held_seg);
        state_next  = state;

        if (seg_changed) begin
            // A new pattern always restarts timing, whatever the state.
            state_next = S_TRACK;
        end else if (state == S_TRACK && stable_cnt == LAST_COUNT) begin
            accept     = 1'b1;
            state_next = S_LOCKED;
        end
    end

    // FSM state register.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (i_Rst) begin
            state <= S_TRACK;
        end else begin
            state <= state_next;
        end
    end

    // Stability filter: capture a changed pattern, otherwise count up while
    // tracking. The count is frozen once the pattern is locked.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            held_seg   <= 7'h00;
            stable_cnt <= 8'd0;
        end else if (seg_changed) begin
            held_seg   <= seg_pattern;
            stable_cnt <= 8'd0;
        end else if (state == S_TRACK && !accept) begin
            stable_cnt <= stable_cnt + 8'd1;
        end
    end

    // Registered outputs: pulses last one clock, o_Binary and o_Blank hold
    // their value between acceptances.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_Binary <= 4'd0;
            o_Valid  <= 1'b0;
            o_Error  <= 1'b0;
            o_Blank  <= 1'b1;
        end else begin
            o_Valid <= 1'b0;
            o_Error <= 1'b0;
            if (accept) begin
                case (held_decode.kind)
                    KIND_DIGIT: begin
                        o_Binary <= held_decode.digit;
                        o_Valid  <= 1'b1;
                        o_Blank  <= 1'b0;
                    end
                    KIND_BLANK: begin
                        o_Blank  <= 1'b1;
                    end
                    default: begin
                        o_Error  <= 1'b1;
                        o_Blank  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef SEG7_ERR_COUNT_EN
    // Saturating count of illegal acceptances; only reset clears it.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_Err_Count <= 8'd0;
        end else if (accept && held_decode.kind == KIND_ILLEGAL
                     && o_Err_Count != 8'hFF) begin
            o_Err_Count <= o_Err_Count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seven_seg_to_binary.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_to_binary
//
// Directed bench for seven_seg_to_binary with the default STABLE_CYCLES = 4.
// A table of patterns is applied back to back, each held six clocks, followed
// by hand-written sequences for latency, glitch, illegal-pattern storm and
// reset corner cases. Build with SEG7_ERR_COUNT_EN to also check o_Err_Count.
// -----------------------------------------------------------------------------
module tb_seven_seg_to_binary;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] pat = 7'h00;
    logic [3:0] binary;
    logic       valid;
    logic       blank;
    logic       error;
`ifdef SEG7_ERR_COUNT_EN
    logic [7:0] err_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // pulse bookkeeping collected by tick()
    int         valid_seen;
    int         error_seen;
    int         both_seen;
    logic [3:0] last_valid_bin;

    always #5 clk = ~clk;

    seven_seg_to_binary #(.STABLE_CYCLES(4)) dut (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .i_Seg_a    (pat[6]),
        .i_Seg_b    (pat[5]),
        .i_Seg_c    (pat[4]),
        .i_Seg_d    (pat[3]),
        .i_Seg_e    (pat[2]),
        .i_Seg_f    (pat[1]),
        .i_Seg_g    (pat[0]),
        .o_Binary   (binary),
        .o_Valid    (valid),
        .o_Blank    (blank),
        .o_Error    (error)
`ifdef SEG7_ERR_COUNT_EN
        ,
        .o_Err_Count(err_count)
`endif
    );

    typedef struct {
        logic [6:0] pat;
        int         exp_valid;
        int         exp_error;
        logic [3:0] exp_bin;
        logic       exp_blank;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic clear_seen();
        valid_seen = 0;
        error_seen = 0;
        both_seen  = 0;
    endtask

    // Advance n clocks, observing outputs 1 ns after each rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                valid_seen++;
                last_valid_bin = binary;
            end
            if (error) error_seen++;
            if (valid && error) both_seen++;
        end
    endtask

    initial begin
        // digits in order, then blank, digit, illegal codes and a digit
        vecs[0]  = '{7'h7E, 1, 0, 4'd0, 1'b0};
        vecs[1]  = '{7'h30, 1, 0, 4'd1, 1'b0};
        vecs[2]  = '{7'h6D, 1, 0, 4'd2, 1'b0};
        vecs[3]  = '{7'h79, 1, 0, 4'd3, 1'b0};
        vecs[4]  = '{7'h33, 1, 0, 4'd4, 1'b0};
        vecs[5]  = '{7'h5B, 1, 0, 4'd5, 1'b0};
        vecs[6]  = '{7'h5F, 1, 0, 4'd6, 1'b0};
        vecs[7]  = '{7'h70, 1, 0, 4'd7, 1'b0};
        vecs[8]  = '{7'h7F, 1, 0, 4'd8, 1'b0};
        vecs[9]  = '{7'h7B, 1, 0, 4'd9, 1'b0};
        vecs[10] = '{7'h00, 0, 0, 4'd9, 1'b1};
        vecs[11] = '{7'h79, 1, 0, 4'd3, 1'b0};
        vecs[12] = '{7'h01, 0, 1, 4'd3, 1'b0};
        vecs[13] = '{7'h00, 0, 0, 4'd3, 1'b1};
        vecs[14] = '{7'h08, 0, 1, 4'd3, 1'b0};
        vecs[15] = '{7'h30, 1, 0, 4'd1, 1'b0};

        // ---------------- reset values ----------------
        #1 rst = 1'b1;
        #2;
        check("reset binary", 32'(binary), 0);
        check("reset valid", 32'(valid), 0);
        check("reset error", 32'(error), 0);
        check("reset blank", 32'(blank), 1);
`ifdef SEG7_ERR_COUNT_EN
        check("reset err_count", 32'(err_count), 0);
`endif

        // ---------------- first digit latency ----------------
        @(posedge clk);
        #1;
        rst = 1'b0;
        pat = 7'h30;
        clear_seen();
        for (int e = 0; e <= 5; e++) begin
            tick(1);
            check($sformatf("latency valid edge %0d", e), 32'(valid),
                  (e == 4) ? 32'd1 : 32'd0);
            if (e == 4) begin
                check("latency binary", 32'(binary), 1);
                check("latency blank", 32'(blank), 0);
            end
        end
        clear_seen();
        tick(20);
        check("held pattern no repeat", 32'(valid_seen), 0);

        // ---------------- table sweep ----------------
        for (int v = 0; v < 16; v++) begin
            pat = vecs[v].pat;
            clear_seen();
            tick(6);
            check($sformatf("vec %0d valid pulses", v), 32'(valid_seen),
                  32'(vecs[v].exp_valid));
            check($sformatf("vec %0d error pulses", v), 32'(error_seen),
                  32'(vecs[v].exp_error));
            check($sformatf("vec %0d binary", v), 32'(binary),
                  32'(vecs[v].exp_bin));
            check($sformatf("vec %0d blank", v), 32'(blank),
                  32'(vecs[v].exp_blank));
        end

        // ---------------- glitch during filtering ----------------
        pat = 7'h5B;
        clear_seen();
        tick(3);            // edges 0..2: loaded, count reaches 2
        pat = 7'h7F;
        tick(1);            // glitch sampled for one edge
        pat = 7'h5B;
        for (int e = 0; e <= 5; e++) begin
            tick(1);
            check($sformatf("glitch valid edge %0d", e), 32'(valid),
                  (e == 4) ? 32'd1 : 32'd0);
        end
        check("glitch single pulse", 32'(valid_seen), 1);
        check("glitch binary", 32'(last_valid_bin), 5);
        check("glitch no error", 32'(error_seen), 0);

        // ---------------- illegal storm ----------------
        clear_seen();
        for (int r = 0; r < 300; r++) begin
            pat = 7'h01;
            tick(5);
            pat = 7'h7E;
            tick(5);
        end
        check("storm error pulses", 32'(error_seen), 300);
        check("storm valid pulses", 32'(valid_seen), 300);
        check("storm never both", 32'(both_seen), 0);
`ifdef SEG7_ERR_COUNT_EN
        check("storm err_count saturated", 32'(err_count), 255);
`endif

        // ---------------- reset mid-filter ----------------
        pat = 7'h7B;
        tick(6);
        check("pre-reset binary", 32'(binary), 9);
        pat = 7'h33;
        tick(3);            // count is 2
        #2 rst = 1'b1;
        #1;
        check("midreset binary", 32'(binary), 0);
        check("midreset blank", 32'(blank), 1);
        check("midreset valid", 32'(valid), 0);
`ifdef SEG7_ERR_COUNT_EN
        check("midreset err_count", 32'(err_count), 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_seen();
        for (int e = 0; e <= 4; e++) begin
            tick(1);
            check($sformatf("post-reset valid edge %0d", e), 32'(valid),
                  (e == 4) ? 32'd1 : 32'd0);
        end
        check("post-reset binary", 32'(binary), 4);

        // ---------------- reset clears a live pulse ----------------
        pat = 7'h00;
        #2 rst = 1'b1;
        #1;
        check("reset kills pulse", 32'(valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_seen();
        tick(8);
        check("silent blank no valid", 32'(valid_seen), 0);
        check("silent blank no error", 32'(error_seen), 0);
        check("silent blank level", 32'(blank), 1);
        check("silent blank binary", 32'(binary), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

endmodule
